// File: rtl/div_signi_seq_if.sv
// Operand/result bundle for the sequential significand divider.
// Latency: n/a (wiring only).
// Backpressure: o_ready gates i_valid; o_valid is a single-cycle pulse with no ready.
//
// Ports carried:
//   i_valid, i_div_one (2*WIDTH dividend), i_div_two (WIDTH divisor) : requester -> divider
//   o_ready, o_valid, o_quo (2*WIDTH), o_rem (WIDTH), o_div_zero     : divider -> requester
interface div_signi_seq_if #(
  parameter int WIDTH = 24
);
  logic                 i_valid;
  logic [2*WIDTH-1:0]   i_div_one;
  logic [WIDTH-1:0]     i_div_two;
  logic                 o_ready;
  logic                 o_valid;
  logic [2*WIDTH-1:0]   o_quo;
  logic [WIDTH-1:0]     o_rem;
  logic                 o_div_zero;

  modport master (
    output i_valid, i_div_one, i_div_two,
    input  o_ready, o_valid, o_quo, o_rem, o_div_zero
  );

  modport slave (
    input  i_valid, i_div_one, i_div_two,
    output o_ready, o_valid, o_quo, o_rem, o_div_zero
  );
endinterface

// File: rtl/div_signi_seq.sv
// Radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor -> quotient, remainder.
// Latency: o_valid in the cycle after accept edge + 2*WIDTH; divide-by-zero: cycle after accept.
// Backpressure: o_ready only in IDLE, one op in flight; results are not held off (pulse output).
//
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : div_signi_seq_if.slave (handshake, operands, quotient/remainder/div-zero)
module div_signi_seq #(
  parameter int WIDTH = 24
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  div_signi_seq_if.slave       bus
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;

  // Dividend bits shift out of the top while quotient bits fill in from the bottom.
  logic [DW-1:0]     shreg;
  logic [WIDTH-1:0]  dvs;
  logic [WIDTH:0]    rem_p;
  logic [CW-1:0]     cnt;

  logic [WIDTH:0]    r_sh;
  logic              q_bit;
  logic [WIDTH:0]    r_new;
  logic [DW-1:0]     sh_new;
  logic              last;
  logic              accept;
  logic              div_zero_in;

  // One restoring step. The extra partial-remainder bit keeps the compare exact
  // after the shift; the result after subtraction always fits back in WIDTH bits.
  always_comb begin
    r_sh   = {rem_p[WIDTH-1:0], shreg[DW-1]};
    q_bit  = (r_sh >= {1'b0, dvs});
    r_new  = q_bit ? (r_sh - {1'b0, dvs}) : r_sh;
    sh_new = {shreg[DW-2:0], q_bit};
  end

  assign last        = (cnt == CW'(DW - 1));
  assign accept      = (state == IDLE) && bus.i_valid;
  assign div_zero_in = (bus.i_div_two == '0);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    bus.o_ready = 1'b0;
    bus.o_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) begin
          next_state = div_zero_in ? DONE : CALC;
        end
      end
      CALC: begin
        if (last) begin
          next_state = DONE;
        end
      end
      DONE: begin
        bus.o_valid = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shreg          <= '0;
      dvs            <= '0;
      rem_p          <= '0;
      cnt            <= '0;
      bus.o_quo      <= '0;
      bus.o_rem      <= '0;
      bus.o_div_zero <= 1'b0;
    end else begin
      if (accept) begin
        shreg <= bus.i_div_one;
        dvs   <= bus.i_div_two;
        rem_p <= '0;
        cnt   <= '0;
        // Divide-by-zero skips the iterations; results are produced straight away.
        if (div_zero_in) begin
          bus.o_quo      <= '1;
          bus.o_rem      <= bus.i_div_one[WIDTH-1:0];
          bus.o_div_zero <= 1'b1;
        end
      end else if (state == CALC) begin
        shreg <= sh_new;
        rem_p <= r_new;
        cnt   <= cnt + CW'(1);
        if (last) begin
          bus.o_quo      <= sh_new;
          bus.o_rem      <= r_new[WIDTH-1:0];
          bus.o_div_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_signi_seq.sv
// Directed bench for div_signi_seq: reset, basic division, round trips, boundaries,
// divide-by-zero, handshake/back-to-back, reset during a division.
module tb_div_signi_seq;

  localparam int W = 24;

  logic clk;
  logic rst_n;

  div_signi_seq_if #(.WIDTH(W)) bus ();

  div_signi_seq #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [2*W-1:0] q;
  logic [W-1:0]   r;
  logic           dz;
  int             lat;
  bit             to;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Issue one op and capture the result in the DONE cycle. lat counts rising
  // edges between the accept edge and the edge that raised o_valid.
  // Returns at the falling edge inside the DONE cycle.
  task automatic do_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
    int g;
    g   = 0;
    to  = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!bus.o_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    bus.i_valid   = 1'b1;
    bus.i_div_one = a;
    bus.i_div_two = b;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    while (!bus.o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.o_valid) to = 1'b1;
    q  = bus.o_quo;
    r  = bus.o_rem;
    dz = bus.o_div_zero;
  endtask

  task automatic test_reset();
    bit seen;
    rst_n         = 1'b0;
    bus.i_valid   = 1'b1;
    bus.i_div_one = 48'd9;
    bus.i_div_two = 24'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.o_ready); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
    checks++; if (bus.o_quo !== 48'd0) begin errors++; $display("FAIL reset_quo: got %h want 0", bus.o_quo); end
    checks++; if (bus.o_rem !== 24'd0) begin errors++; $display("FAIL reset_rem: got %h want 0", bus.o_rem); end
    checks++; if (bus.o_div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", bus.o_div_zero); end
    bus.i_valid = 1'b0;
    rst_n       = 1'b1;
    seen        = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL reset_no_accept: got activity after reset-time valid, want none"); end
  endtask

  task automatic test_basic();
    do_op(48'd1000000, 24'd1);
    checks++; if (lat !== 2*W) begin errors++; $display("FAIL basic_latency: got %0d want %0d", lat, 2*W); end
    checks++; if (q !== 48'd1000000) begin errors++; $display("FAIL basic_quo: got %0d want 1000000", q); end
    checks++; if (r !== 24'd0) begin errors++; $display("FAIL basic_rem: got %0d want 0", r); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL basic_dz: got %b want 0", dz); end
    for (int d = 10000; d <= 10100; d++) begin
      do_op(48'(d), 24'd1);
      checks++;
      if (to || q !== 48'(d) || r !== 24'd0) begin
        errors++;
        $display("FAIL sweep_div1: dividend %0d got quo %0d rem %0d timeout %b, want quo %0d rem 0", d, q, r, to, d);
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [W-1:0]   a, b, c;
    logic [2*W-1:0] prod;
    do_op(48'd97406784, 24'd789);
    checks++; if (q !== 48'd123456) begin errors++; $display("FAIL rt_quo: got %0d want 123456", q); end
    checks++; if (r !== 24'd0) begin errors++; $display("FAIL rt_rem: got %0d want 0", r); end
    for (int i = 0; i < 20; i++) begin
      a    = W'($urandom_range(32'hFFFFFF, 1));
      b    = W'($urandom_range(32'hFFFFFF, 1));
      c    = (i % 2 == 0) ? W'(0) : W'($urandom_range(32'(b) - 1, 0));
      prod = 48'(a) * 48'(b) + 48'(c);
      do_op(prod, b);
      checks++;
      if (to || q !== 48'(a) || r !== c) begin
        errors++;
        $display("FAIL rt_random: %0d/%0d got quo %0d rem %0d, want quo %0d rem %0d", prod, b, q, r, a, c);
      end
    end
  endtask

  task automatic test_boundary();
    logic [2*W-1:0] ta [5];
    logic [W-1:0]   tb [5];
    logic [2*W-1:0] eq [5];
    logic [W-1:0]   er [5];
    ta[0] = 48'd0;              tb[0] = 24'd7;        eq[0] = 48'd0;              er[0] = 24'd0;
    ta[1] = 48'd12345;          tb[1] = 24'd1000000;  eq[1] = 48'd0;              er[1] = 24'd12345;
    ta[2] = 48'hFFFF_FFFF_FFFF; tb[2] = 24'd1;        eq[2] = 48'hFFFF_FFFF_FFFF; er[2] = 24'd0;
    ta[3] = 48'hFFFF_FFFF_FFFF; tb[3] = 24'hFFFFFF;   eq[3] = 48'h1_000_001;      er[3] = 24'd0;
    ta[4] = 48'd16777215;       tb[4] = 24'd4096;     eq[4] = 48'd4095;           er[4] = 24'd4095;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb[i]);
      checks++;
      if (to || q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
        errors++;
        $display("FAIL boundary_%0d: got quo %h rem %h dz %b, want quo %h rem %h dz 0", i, q, r, dz, eq[i], er[i]);
      end
    end
    repeat (5) @(negedge clk);
    checks++; if (bus.o_quo !== 48'd4095 || bus.o_rem !== 24'd4095) begin
      errors++; $display("FAIL output_hold: got quo %0d rem %0d want 4095/4095", bus.o_quo, bus.o_rem);
    end
  endtask

  task automatic test_div_zero();
    do_op(48'd55, 24'd0);
    checks++; if (lat !== 0) begin errors++; $display("FAIL dz_latency: got %0d want 0", lat); end
    checks++; if (q !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL dz_quo: got %h want ffffffffffff", q); end
    checks++; if (r !== 24'd55) begin errors++; $display("FAIL dz_rem: got %0d want 55", r); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", dz); end
    do_op(48'd20, 24'd3);
    checks++; if (lat !== 2*W) begin errors++; $display("FAIL after_dz_latency: got %0d want %0d", lat, 2*W); end
    checks++; if (q !== 48'd6 || r !== 24'd2) begin errors++; $display("FAIL after_dz_result: got %0d r %0d want 6 r 2", q, r); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL after_dz_flag: got %b want 0", dz); end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] eq [2];
    logic [W-1:0]   er [2];
    int low, n;
    eq[0] = 48'd14; er[0] = 24'd2;
    eq[1] = 48'd22; er[1] = 24'd2;
    @(negedge clk);
    bus.i_valid = 1'b1;
    for (int op = 0; op < 2; op++) begin
      bus.i_div_one = (op == 0) ? 48'd100 : 48'd200;
      bus.i_div_two = (op == 0) ? 24'd7 : 24'd9;
      @(posedge clk);
      low = 0;
      n   = 0;
      @(negedge clk);
      while (!bus.o_valid && n < 200) begin
        if (!bus.o_ready) low++;
        bus.i_div_one = 48'(5000 + n);
        bus.i_div_two = 24'(n % 4);
        n++;
        @(negedge clk);
      end
      if (!bus.o_ready) low++;
      checks++; if (bus.o_quo !== eq[op] || bus.o_rem !== er[op]) begin
        errors++; $display("FAIL b2b_result_%0d: got %0d r %0d want %0d r %0d", op, bus.o_quo, bus.o_rem, eq[op], er[op]);
      end
      checks++; if (low !== 2*W + 1) begin
        errors++; $display("FAIL b2b_ready_low_%0d: got %0d cycles want %0d", op, low, 2*W + 1);
      end
      @(negedge clk);
      if (op == 1) bus.i_valid = 1'b0;
      checks++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_pulse_%0d: got valid %b ready %b want 0 1", op, bus.o_valid, bus.o_ready);
      end
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus.i_div_one = 48'd1000;
    bus.i_div_two = 24'd3;
    bus.i_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
      if (i == 10) begin
        checks++; if (bus.o_quo !== 48'd22) begin errors++; $display("FAIL hold_during_calc: got %0d want 22", bus.o_quo); end
      end
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_hs: got ready %b valid %b want 1 0", bus.o_ready, bus.o_valid);
    end
    checks++; if (bus.o_quo !== 48'd0 || bus.o_rem !== 24'd0 || bus.o_div_zero !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs: got quo %0d rem %0d dz %b want 0 0 0", bus.o_quo, bus.o_rem, bus.o_div_zero);
    end
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (bus.o_valid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrst_no_pulse: got an o_valid pulse want none"); end
    do_op(48'd1000, 24'd3);
    checks++; if (to || q !== 48'd333 || r !== 24'd1) begin
      errors++; $display("FAIL midrst_fresh: got %0d r %0d want 333 r 1", q, r);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_div_one = '0;
    bus.i_div_two = '0;
    test_reset();
    test_basic();
    test_roundtrip();
    test_boundary();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
